// File: rtl/dtcm_icb_if.sv
// dtcm_icb_if: ICB command/response bus between the LSU and the DTCM controller
interface dtcm_icb_if #(parameter int DW = 32);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_read;
  logic [31:0]     cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_cancel;
  logic            rsp_err;
  modport master (output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_rdata, rsp_cancel, rsp_err);
  modport slave  (input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_rdata, rsp_cancel, rsp_err);
endinterface

// File: rtl/dtcm_icb_ctrl.sv
// dtcm_icb_ctrl: ICB-to-SRAM DTCM controller, 1-cycle read path plus 2-entry response FIFO.
// Define HiCore_DTCM_MISALIGN_CHK_EN to reject non-word-aligned accesses with rsp_err.
module dtcm_icb_ctrl #(
  parameter int DW        = 32,
  parameter int RAM_DEPTH = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dtcm_icb_if.slave            dtcm_icb,
  input  logic                 flush,
  input  logic                 branch,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [RAM_DEPTH-1:0] sram_addr,
  output logic [DW-1:0]        sram_wdata,
  output logic [DW/8-1:0]      sram_wem,
  input  logic [DW-1:0]        sram_rdata
);
  logic          accept, kill, mis, empty, pop, handoff, push, p_cancel_nx;
  logic          p_valid, p_read, p_err, p_cancel;
  logic [1:0]    cnt;
  logic          wp, rp;
  logic [DW-1:0] p_rdata;
  logic [DW-1:0] f_rdata [2];
  logic [1:0]    f_read, f_err, f_cancel;
`ifdef HiCore_DTCM_MISALIGN_CHK_EN
  assign mis = dtcm_icb.cmd_addr[1:0] != 2'b00;
  logic unused_addr;
  assign unused_addr = ^dtcm_icb.cmd_addr[31:RAM_DEPTH+2];
`else
  assign mis = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{dtcm_icb.cmd_addr[31:RAM_DEPTH+2], dtcm_icb.cmd_addr[1:0]};
`endif
  assign kill        = flush | branch;
  assign empty       = cnt == 2'd0;
  assign dtcm_icb.cmd_ready = ({1'b0, cnt} + {2'b00, p_valid}) < 3'd2;
  assign accept      = dtcm_icb.cmd_valid & dtcm_icb.cmd_ready;
  assign sram_cs     = accept & ~mis;
  assign sram_we     = sram_cs & ~dtcm_icb.cmd_read;
  assign sram_addr   = dtcm_icb.cmd_addr[RAM_DEPTH+1:2];
  assign sram_wdata  = dtcm_icb.cmd_wdata;
  assign sram_wem    = dtcm_icb.cmd_wmask;
  assign p_rdata     = (p_valid & p_read & ~p_err) ? sram_rdata : '0;
  assign pop         = ~empty & dtcm_icb.rsp_ready;
  assign handoff     = p_valid & empty & dtcm_icb.rsp_ready;
  assign push        = p_valid & ~handoff;
  // a pending read squashed in the same cycle it moves into the FIFO must carry the cancel
  assign p_cancel_nx = p_cancel | (kill & p_read);
  assign dtcm_icb.rsp_valid  = ~empty | p_valid;
  assign dtcm_icb.rsp_rdata  = empty ? p_rdata : f_rdata[rp];
  assign dtcm_icb.rsp_cancel = empty ? p_valid & p_cancel : f_cancel[rp];
  assign dtcm_icb.rsp_err    = empty ? p_valid & p_err : f_err[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid  <= 1'b0;
      p_read   <= 1'b0;
      p_err    <= 1'b0;
      p_cancel <= 1'b0;
      cnt      <= 2'd0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      f_read   <= 2'b00;
      f_err    <= 2'b00;
      f_cancel <= 2'b00;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_read   <= dtcm_icb.cmd_read;
        p_err    <= mis;
        p_cancel <= kill & dtcm_icb.cmd_read;
      end
      if (kill) f_cancel <= f_cancel | f_read;
      if (push) begin
        f_read[wp]   <= p_read;
        f_err[wp]    <= p_err;
        f_cancel[wp] <= p_cancel_nx;
        wp           <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (push) f_rdata[wp] <= p_rdata;
  end
endmodule

// File: tb/tb_dtcm_icb_ctrl.sv
// tb_dtcm_icb_ctrl: directed checks of the DTCM controller against a behavioural SRAM.
module tb_dtcm_icb_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, branch;
  logic        sram_cs, sram_we;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic [3:0]  sram_wem;
  logic [31:0] mem [0:16383];
  int          checks = 0;
  int          failures = 0;
  dtcm_icb_if #(.DW(32)) bus ();
  dtcm_icb_ctrl #(.DW(32), .RAM_DEPTH(14)) dut (
    .clk(clk), .rst_n(rst_n), .dtcm_icb(bus), .flush(flush), .branch(branch),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wem(sram_wem), .sram_rdata(sram_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we)
        for (int b = 0; b < 4; b++)
          if (sram_wem[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= mem[sram_addr];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic v, input logic rd, input logic [31:0] a, input logic [31:0] wd);
    bus.cmd_valid = v;
    bus.cmd_read  = rd;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_wmask = 4'hF;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; flush = 1'b0; branch = 1'b0; bus.rsp_ready = 1'b1;
    drv(0, 0, 0, 0);
    #2;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_cancel", 32'(bus.rsp_cancel), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_sram_cs", 32'(sram_cs), 0);
    chk("rst_sram_we", 32'(sram_we), 0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    // write then read back at 0x100
    drv(1, 0, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_cs", 32'(sram_cs), 1);
    chk("wr_we", 32'(sram_we), 1);
    chk("wr_addr", 32'(sram_addr), 32'h40);
    chk("wr_wem", 32'(sram_wem), 32'hF);
    cyc();
    drv(1, 1, 32'h100, 0);
    @(negedge clk);
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("wr_rsp_rdata", bus.rsp_rdata, 0);
    chk("rd_cs", 32'(sram_cs), 1);
    chk("rd_we", 32'(sram_we), 0);
    chk("rd_addr", 32'(sram_addr), 32'h40);
    cyc();
    drv(0, 0, 0, 0);
    @(negedge clk);
    chk("rd_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_err", 32'(bus.rsp_err), 0);
    chk("rd_rsp_cancel", 32'(bus.rsp_cancel), 0);
    cyc();
    @(negedge clk);
    chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 32'h200 + 32'(4 * i), 32'hA0A0_0000 + 32'(i));
      cyc();
    end
    drv(0, 0, 0, 0);
    cyc();
    // four back-to-back reads, one response per cycle
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 32'h200 + 32'(4 * i), 0);
      @(negedge clk);
      chk("b2b_ready", 32'(bus.cmd_ready), 1);
      if (i > 0) begin
        chk("b2b_valid", 32'(bus.rsp_valid), 1);
        chk("b2b_rdata", bus.rsp_rdata, 32'hA0A0_0000 + 32'(i - 1));
      end
      cyc();
    end
    drv(0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_valid3", 32'(bus.rsp_valid), 1);
    chk("b2b_rdata3", bus.rsp_rdata, 32'hA0A0_0003);
    cyc();
    @(negedge clk);
    chk("b2b_drain", 32'(bus.rsp_valid), 0);
    cyc();
    // back-pressure: third read stalls
    bus.rsp_ready = 1'b0;
    drv(1, 1, 32'h200, 0);
    @(negedge clk);
    chk("bp_ready0", 32'(bus.cmd_ready), 1);
    cyc();
    drv(1, 1, 32'h204, 0);
    @(negedge clk);
    chk("bp_ready1", 32'(bus.cmd_ready), 1);
    cyc();
    drv(1, 1, 32'h208, 0);
    @(negedge clk);
    chk("bp_ready2", 32'(bus.cmd_ready), 0);
    chk("bp_cs2", 32'(sram_cs), 0);
    chk("bp_head", bus.rsp_rdata, 32'hA0A0_0000);
    cyc();
    drv(0, 0, 0, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_full_ready", 32'(bus.cmd_ready), 0);
    chk("bp_rsp0", bus.rsp_rdata, 32'hA0A0_0000);
    cyc();
    @(negedge clk);
    chk("bp_rsp1", bus.rsp_rdata, 32'hA0A0_0001);
    chk("bp_ready_back", 32'(bus.cmd_ready), 1);
    cyc();
    @(negedge clk);
    chk("bp_empty", 32'(bus.rsp_valid), 0);
    cyc();
    // flush with two reads outstanding
    bus.rsp_ready = 1'b0;
    drv(1, 1, 32'h200, 0);
    cyc();
    drv(1, 1, 32'h204, 0);
    cyc();
    drv(0, 0, 0, 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("fl_valid0", 32'(bus.rsp_valid), 1);
    chk("fl_cancel0", 32'(bus.rsp_cancel), 1);
    chk("fl_rdata0", bus.rsp_rdata, 32'hA0A0_0000);
    cyc();
    @(negedge clk);
    chk("fl_cancel1", 32'(bus.rsp_cancel), 1);
    chk("fl_rdata1", bus.rsp_rdata, 32'hA0A0_0001);
    cyc();
    drv(1, 1, 32'h208, 0);
    cyc();
    drv(0, 0, 0, 0);
    @(negedge clk);
    chk("fl_after_cancel", 32'(bus.rsp_cancel), 0);
    chk("fl_after_rdata", bus.rsp_rdata, 32'hA0A0_0002);
    cyc();
    drv(1, 1, 32'h20C, 0);
    branch = 1'b1;
    cyc();
    branch = 1'b0;
    drv(0, 0, 0, 0);
    @(negedge clk);
    chk("br_same_valid", 32'(bus.rsp_valid), 1);
    chk("br_same_cancel", 32'(bus.rsp_cancel), 1);
    cyc();
    drv(1, 0, 32'h300, 32'h1234_5678);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_wr_we", 32'(sram_we), 1);
    cyc();
    flush = 1'b0;
    drv(0, 0, 0, 0);
    @(negedge clk);
    chk("fl_wr_valid", 32'(bus.rsp_valid), 1);
    chk("fl_wr_cancel", 32'(bus.rsp_cancel), 0);
    cyc();
    // misaligned read
    drv(1, 1, 32'h102, 0);
    @(negedge clk);
`ifdef HiCore_DTCM_MISALIGN_CHK_EN
    chk("mis_cs", 32'(sram_cs), 0);
`else
    chk("mis_cs", 32'(sram_cs), 1);
    chk("mis_addr", 32'(sram_addr), 32'h40);
`endif
    cyc();
    drv(0, 0, 0, 0);
    @(negedge clk);
    chk("mis_valid", 32'(bus.rsp_valid), 1);
`ifdef HiCore_DTCM_MISALIGN_CHK_EN
    chk("mis_err", 32'(bus.rsp_err), 1);
    chk("mis_rdata", bus.rsp_rdata, 0);
`else
    chk("mis_err", 32'(bus.rsp_err), 0);
    chk("mis_rdata", bus.rsp_rdata, 32'hDEADBEEF);
`endif
    cyc();
    // reset with FIFO full
    bus.rsp_ready = 1'b0;
    drv(1, 1, 32'h200, 0);
    cyc();
    drv(1, 1, 32'h204, 0);
    cyc();
    drv(0, 0, 0, 0);
    cyc();
    @(negedge clk);
    chk("full_valid", 32'(bus.rsp_valid), 1);
    chk("full_ready", 32'(bus.cmd_ready), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.rsp_valid), 0);
    chk("arst_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.rsp_valid), 0);
    chk("post_rst_ready", 32'(bus.cmd_ready), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
